cache_assoc: RTL and testbench

Parametrised N-way set-associative, read-only instruction/data cache. It is the next-generation replacement for the direct-mapped lookup path. It adds configurable set count and associativity, a request/response handshake, and a miss-refill state machine that fetches from main memory over a valid-qualified port. It also supports per-set flush and deterministic victim selection. It sits between the core fetch/load stage and the main-memory read port.

---
 rtl/cache_assoc.sv | 168 ++++++++++++++++
 tb/tb_cache_assoc.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc.sv
// N-way set-associative read-only cache with round-robin refill and per-set flush.
// Per-way tag compare lives in cache_assoc_way, instantiated once per way.

module cache_assoc_way #(
  parameter int TAG_W = 26
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_q,
  input  logic [TAG_W-1:0] tag_in,
  output logic             hit
);
  assign hit = vld && (tag_q == tag_in);
endmodule

module cache_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddress,
  output logic              oReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oHit,
  input  logic              iFlush,
  input  logic [ADDR_W-1:0] iFlushAddress,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddress,
  input  logic              iMemValid,
  input  logic [DATA_W-1:0] iMemData
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;
  state_t state, state_nx;

  logic [SETS-1:0][WAYS-1:0]  vld_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [TAG_W-1:0]           tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]          data_mem [SETS][WAYS];

  // Only the word address of the outstanding miss is kept.
  logic [ADDR_W-3:0] req_word;
  logic [DATA_W-1:0] fill_data;

  logic [IDX_W-1:0] lk_idx, fl_idx, fsh_idx;
  logic [TAG_W-1:0] lk_tag, fl_tag;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any;
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0] vic_way;
  logic             vic_free;
  logic             accept;

  logic unused_bits;
  assign unused_bits = ^{iAddress[1:0], iFlushAddress[ADDR_W-1:IDX_W+2], iFlushAddress[1:0]};

  assign lk_idx  = iAddress[IDX_W+1:2];
  assign lk_tag  = iAddress[ADDR_W-1:IDX_W+2];
  assign fl_idx  = req_word[IDX_W-1:0];
  assign fl_tag  = req_word[ADDR_W-3:IDX_W];
  assign fsh_idx = iFlushAddress[IDX_W+1:2];

  assign oMemAddress = {req_word, 2'b00};

  genvar g;
  generate
    for (g = 0; g < WAYS; g++) begin : g_way
      cache_assoc_way #(.TAG_W(TAG_W)) u_way (
        .vld    (vld_q[lk_idx][g]),
        .tag_q  (tag_mem[lk_idx][g]),
        .tag_in (lk_tag),
        .hit    (hit_vec[g])
      );
    end
  endgenerate

  always_comb begin
    hit_any  = |hit_vec;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_data = data_mem[lk_idx][w];
  end

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    vic_way  = rr_q[fl_idx];
    vic_free = 1'b0;
    for (int w = WAYS-1; w >= 0; w--)
      if (!vld_q[fl_idx][w]) begin
        vic_way  = WAY_W'(w);
        vic_free = 1'b1;
      end
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oReady   = 1'b0;
    oMemReq  = 1'b0;
    case (state)
      IDLE: begin
        oReady = !iFlush && !iRst;
        if (iReq && oReady && !hit_any) state_nx = MISS;
      end
      MISS: begin
        oMemReq = 1'b1;
        if (iMemValid) state_nx = FILL;
      end
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = iReq && oReady;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_q     <= '0;
      rr_q      <= '0;
      oValid    <= 1'b0;
      oHit      <= 1'b0;
      oData     <= '0;
      req_word  <= '0;
      fill_data <= '0;
    end else begin
      oValid <= 1'b0;
      if (accept) begin
        if (hit_any) begin
          oValid <= 1'b1;
          oHit   <= 1'b1;
          oData  <= hit_data;
        end else begin
          req_word <= iAddress[ADDR_W-1:2];
        end
      end
      if (state == MISS && iMemValid) begin
        fill_data <= iMemData;
        oValid    <= 1'b1;
        oHit      <= 1'b0;
        oData     <= iMemData;
      end
      if (iFlush) vld_q[fsh_idx] <= '0;
      // Placed after the flush so an in-flight fill to a flushed set stays valid.
      if (state == FILL) begin
        vld_q[fl_idx][vic_way] <= 1'b1;
        if (!vic_free) rr_q[fl_idx] <= rr_q[fl_idx] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst && state == FILL) begin
      tag_mem[fl_idx][vic_way]  <= fl_tag;
      data_mem[fl_idx][vic_way] <= fill_data;
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed bench for cache_assoc (SETS=16, WAYS=2): refill, eviction order, flush, reset mid-miss.

module tb_cache_assoc;
  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReq;
  logic [31:0] iAddress;
  logic        oReady;
  logic        oValid;
  logic [31:0] oData;
  logic        oHit;
  logic        iFlush;
  logic [31:0] iFlushAddress;
  logic        oMemReq;
  logic [31:0] oMemAddress;
  logic        iMemValid;
  logic [31:0] iMemData;

  int total = 0;
  int bad   = 0;
  logic started = 1'b0;

  always #5 iClk = ~iClk;

  cache_assoc #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(2)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iAddress(iAddress),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oHit(oHit),
    .iFlush(iFlush), .iFlushAddress(iFlushAddress),
    .oMemReq(oMemReq), .oMemAddress(oMemAddress),
    .iMemValid(iMemValid), .iMemData(iMemData)
  );

  always @(negedge iClk)
    if (started && !iRst)
      assert ($onehot0(dut.hit_vec)) else begin
        bad++;
        $error("FAIL multihit observed=%b expected=onehot0", dut.hit_vec);
      end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full read from IDLE; on a miss memory answers after lat extra cycles.
  task automatic do_read(input string tag, input logic [31:0] a, input logic exp_hit,
                         input logic [31:0] d, input int lat);
    iReq = 1'b1; iAddress = a; #1;
    chk({tag, ".ready"}, oReady, 1);
    @(posedge iClk); #1;
    iReq = 1'b0; iAddress = $urandom;
    if (exp_hit) begin
      chk({tag, ".hv"}, oValid, 1);
      chk({tag, ".hit"}, oHit, 1);
      chk({tag, ".hdata"}, oData, d);
      chk({tag, ".nomreq"}, oMemReq, 0);
    end else begin
      chk({tag, ".nv"}, oValid, 0);
      chk({tag, ".mreq"}, oMemReq, 1);
      chk({tag, ".maddr"}, oMemAddress, {a[31:2], 2'b00});
      for (int i = 0; i < lat; i++) begin
        @(posedge iClk); #1;
        chk({tag, ".mreq_hold"}, oMemReq, 1);
        chk({tag, ".maddr_hold"}, oMemAddress, {a[31:2], 2'b00});
      end
      iMemValid = 1'b1; iMemData = d;
      @(posedge iClk); #1;
      iMemValid = 1'b0; iMemData = $urandom;
      chk({tag, ".fv"}, oValid, 1);
      chk({tag, ".fhit"}, oHit, 0);
      chk({tag, ".fdata"}, oData, d);
      chk({tag, ".fmreq"}, oMemReq, 0);
      chk({tag, ".fready"}, oReady, 0);
    end
    @(posedge iClk); #1;
    chk({tag, ".vdrop"}, oValid, 0);
    chk({tag, ".dhold"}, oData, d);
    chk({tag, ".ready2"}, oReady, 1);
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0; #1;
  endtask

  initial begin
    iRst = 1'b1; iReq = 1'b0; iAddress = '0; iFlush = 1'b0; iFlushAddress = '0;
    iMemValid = 1'b0; iMemData = '0;

    // reset state
    repeat (2) @(posedge iClk);
    #1;
    chk("rst.ready", oReady, 0);
    chk("rst.valid", oValid, 0);
    chk("rst.hit", oHit, 0);
    chk("rst.data", oData, 0);
    chk("rst.mreq", oMemReq, 0);
    chk("rst.maddr", oMemAddress, 0);
    iRst = 1'b0; #1;
    chk("rst.ready_after", oReady, 1);
    started = 1'b1;

    // basic miss then hit
    do_read("m40", 32'h40, 1'b0, 32'hDEAD_BEEF, 0);
    do_read("h40", 32'h40, 1'b1, 32'hDEAD_BEEF, 0);

    // eviction order in set 0
    do_reset();
    do_read("m000", 32'h000, 1'b0, 32'h0000_A000, 1);
    do_read("m040", 32'h040, 1'b0, 32'h0000_A040, 0);
    do_read("m080", 32'h080, 1'b0, 32'h0000_A080, 2);
    do_read("h040", 32'h040, 1'b1, 32'h0000_A040, 0);
    do_read("m000b", 32'h000, 1'b0, 32'h0000_B000, 0);
    do_read("h080", 32'h080, 1'b1, 32'h0000_A080, 0);

    // back-to-back hits
    iReq = 1'b1; iAddress = 32'h080;
    @(posedge iClk); #1;
    iAddress = 32'h000;
    chk("b2b.v0", oValid, 1);
    chk("b2b.d0", oData, 32'h0000_A080);
    @(posedge iClk); #1;
    iReq = 1'b0;
    chk("b2b.v1", oValid, 1);
    chk("b2b.h1", oHit, 1);
    chk("b2b.d1", oData, 32'h0000_B000);
    @(posedge iClk); #1;

    // hits leave the round-robin pointer alone
    do_read("m004", 32'h004, 1'b0, 32'h0000_C004, 0);
    do_read("m044", 32'h044, 1'b0, 32'h0000_C044, 0);
    for (int i = 0; i < 10; i++) do_read("h004", 32'h004, 1'b1, 32'h0000_C004, 0);
    do_read("m084", 32'h084, 1'b0, 32'h0000_C084, 0);
    do_read("h044", 32'h044, 1'b1, 32'h0000_C044, 0);

    // flush collides with request
    iFlush = 1'b1; iFlushAddress = 32'h44; iReq = 1'b1; iAddress = 32'h080; #1;
    chk("fl.ready", oReady, 0);
    @(posedge iClk); #1;
    iFlush = 1'b0; iReq = 1'b0;
    chk("fl.novalid", oValid, 0);
    chk("fl.nomreq", oMemReq, 0);
    do_read("fl.m044", 32'h044, 1'b0, 32'h0000_D044, 0);
    do_read("fl.h080", 32'h080, 1'b1, 32'h0000_A080, 0);

    // flush of the same set during MISS
    iReq = 1'b1; iAddress = 32'h84;
    @(posedge iClk); #1;
    iReq = 1'b0;
    chk("fm.mreq", oMemReq, 1);
    iFlush = 1'b1; iFlushAddress = 32'h84;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    chk("fm.mreq_hold", oMemReq, 1);
    iMemValid = 1'b1; iMemData = 32'h0000_E084;
    @(posedge iClk); #1;
    iMemValid = 1'b0;
    chk("fm.fv", oValid, 1);
    chk("fm.fdata", oData, 32'h0000_E084);
    @(posedge iClk); #1;
    do_read("fm.h084", 32'h084, 1'b1, 32'h0000_E084, 0);
    do_read("fm.m044", 32'h044, 1'b0, 32'h0000_F044, 0);

    // reset during MISS
    iReq = 1'b1; iAddress = 32'h1C0;
    @(posedge iClk); #1;
    iReq = 1'b0;
    chk("rm.mreq", oMemReq, 1);
    iRst = 1'b1;
    @(posedge iClk); #1;
    chk("rm.mreq_drop", oMemReq, 0);
    chk("rm.novalid", oValid, 0);
    chk("rm.ready_rst", oReady, 0);
    iRst = 1'b0;
    iMemValid = 1'b1; iMemData = 32'h5555_5555;
    @(posedge iClk); #1;
    iMemValid = 1'b0;
    chk("rm.late_novalid", oValid, 0);
    chk("rm.late_nomreq", oMemReq, 0);
    chk("rm.late_data", oData, 0);
    do_read("rm.m1c0", 32'h1C0, 1'b0, 32'h0000_11C0, 2);
    do_read("rm.m080", 32'h080, 1'b0, 32'h0000_2080, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
